// File: rtl/execute_md_pkg.sv
// Shared constants for the execute stage: widths, select/op encodings,
// and the multiply/divide FSM state type.
package execute_md_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ASEL_W   = 2;
  localparam int unsigned BSEL_W   = 2;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned MDOP_W   = 3;

  typedef enum logic [ASEL_W-1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [BSEL_W-1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2,
    B_ZERO = 2'd3
  } b_sel_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [MDOP_W-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/execute_md_alu.sv
// Single-cycle integer ALU.
module alu
  import execute_md_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]    a_i,
  input  logic [XLEN-1:0]    b_i,
  input  logic [ALUOP_W-1:0] op_i,
  output logic [XLEN-1:0]    y_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  assign sh = b_i[SHW-1:0];

  // Operation select.
  always_comb begin
    y_o = '0;
    case (alu_op_e'(op_i))
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << sh;
      ALU_SLT:  y_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU: y_o = XLEN'(a_i < b_i);
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> sh;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> sh);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_md_md_unit.sv
// Iterative multiply/divide: radix-2 shift-add multiply, restoring divide,
// operating on magnitudes with the sign applied to the final result.
module md_unit
  import execute_md_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MDOP_W-1:0] op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              ack_i,
  output logic              idle_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier -> product low / dividend -> quotient
  logic [XLEN-1:0] opd_q, opd_d;   // multiplicand / divisor magnitude
  md_op_e          op_q, op_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d, div0_q, div0_d;

  logic            sa, sb;
  logic [XLEN:0]   mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] q_s, r_s;

  assign idle_o = (state_q == MD_IDLE);
  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

  // Datapath step values and sign-corrected results.
  always_comb begin
    sa      = op_a_signed(md_op_e'(op_i)) & a_i[XLEN-1];
    sb      = op_b_signed(md_op_e'(op_i)) & b_i[XLEN-1];
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    rem_sh  = {acc_q, lo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opd_q};
    prod    = {acc_q, lo_q};
    prod_s  = (a_neg_q ^ b_neg_q) ? -prod : prod;
    q_s     = div0_q ? '1 : ((a_neg_q ^ b_neg_q) ? -lo_q : lo_q);
    r_s     = a_neg_q ? -acc_q : acc_q;
    result_o = '0;
    case (op_q)
      MD_MUL:                      result_o = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result_o = q_s;
      MD_REM, MD_REMU:             result_o = r_s;
      default:                     result_o = '0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    div0_d  = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          count_d = CW'(XLEN);
          op_d    = md_op_e'(op_i);
          a_neg_d = sa;
          b_neg_d = sb;
          div0_d  = op_i[2] & (b_i == '0);
          acc_d   = '0;
          lo_d    = sa ? -a_i : a_i;
          opd_d   = sb ? -b_i : b_i;
        end
      end
      MD_BUSY: begin
        count_d = count_q - 1'b1;
        if (!op_q[2]) begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
          acc_d = diff[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
        if (count_q == CW'(1)) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (ack_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      op_q    <= MD_MUL;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      div0_q  <= div0_d;
    end
  end

endmodule

// File: rtl/execute_md.sv
// Execute stage with operand forwarding, single-cycle ALU and an iterative
// M-extension unit; drives the EXE/MEM pipeline register.
module execute_md
  import execute_md_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned DMEM_WIDTH = 10,
  parameter int unsigned FWD_SRCS   = 2,
  parameter int unsigned FSW        = $clog2(FWD_SRCS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_exe,
  input  logic [XLEN-1:0]          pc_exe,
  input  logic [XLEN-1:0]          rs1_exe,
  input  logic [XLEN-1:0]          rs2_exe,
  input  logic [XLEN-1:0]          instr_exe,
  input  logic [XLEN-1:0]          imm_exe,
  input  logic [ASEL_W-1:0]        a_sel,
  input  logic [BSEL_W-1:0]        b_sel,
  input  logic [ALUOP_W-1:0]       alu_op,
  input  logic                     md_en,
  input  logic [MDOP_W-1:0]        md_op,
  input  logic [4:0]               rd_addr_exe,
  input  logic [FSW-1:0]           forward_a_sel,
  input  logic [FSW-1:0]           forward_b_sel,
  input  logic [FWD_SRCS*XLEN-1:0] forward_data,
  input  logic                     stall_mem,
  output logic                     stall_exe,
  output logic                     valid_mem,
  output logic [XLEN-1:0]          pc_mem,
  output logic [XLEN-1:0]          alu_mem,
  output logic [XLEN-1:0]          rs2_mem,
  output logic [XLEN-1:0]          instr_mem,
  output logic [4:0]               rd_addr_mem,
  output logic [DMEM_WIDTH-1:0]    dmem_addr,
  output logic [XLEN-1:0]          dmem_data
);

  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_out, md_result;
  logic            md_idle, md_busy, md_done, md_start;
  logic            retire_alu, retire_md;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, rs2_q, rs2_d, instr_q, instr_d;
  logic [4:0]      rd_q, rd_d;

  // Forwarding muxes; select 0 or any out-of-range value keeps the rs value.
  always_comb begin
    fwd_a = rs1_exe;
    fwd_b = rs2_exe;
    for (int unsigned k = 0; k < FWD_SRCS; k++) begin
      if (forward_a_sel == FSW'(k + 1)) fwd_a = forward_data[k*XLEN +: XLEN];
      if (forward_b_sel == FSW'(k + 1)) fwd_b = forward_data[k*XLEN +: XLEN];
    end
  end

  // ALU operand selection.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (a_sel_e'(a_sel))
      A_RS1:   op_a = fwd_a;
      A_PC:    op_a = pc_exe;
      default: op_a = '0;
    endcase
    case (b_sel_e'(b_sel))
      B_RS2:   op_b = fwd_b;
      B_IMM:   op_b = imm_exe;
      B_FOUR:  op_b = XLEN'(4);
      default: op_b = '0;
    endcase
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a_i  (op_a),
    .b_i  (op_b),
    .op_i (alu_op),
    .y_o  (alu_out)
  );

  assign md_start = valid_exe & md_en;

  md_unit #(.XLEN(XLEN)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .op_i     (md_op),
    .a_i      (fwd_a),
    .b_i      (fwd_b),
    .ack_i    (~stall_mem),
    .idle_o   (md_idle),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign retire_md  = md_done & ~stall_mem;
  assign retire_alu = valid_exe & ~md_en & md_idle & ~stall_mem;
  assign stall_exe  = md_busy | (md_done & stall_mem)
                    | (valid_exe & (stall_mem | (md_en & md_idle)));

  assign dmem_addr = alu_out[DMEM_WIDTH+1:2];
  assign dmem_data = fwd_b;

  // EXE/MEM next-state: hold under stall_mem, bubble when nothing retires.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    rs2_d   = rs2_q;
    instr_d = instr_q;
    rd_d    = rd_q;
    if (!stall_mem) begin
      valid_d = 1'b0;
      if (retire_md) begin
        valid_d = 1'b1;
        alu_d   = md_result;
        pc_d    = pc_exe;
        instr_d = instr_exe;
        rd_d    = rd_addr_exe;
      end else if (retire_alu) begin
        valid_d = 1'b1;
        alu_d   = alu_out;
        pc_d    = pc_exe;
        rs2_d   = fwd_b;
        instr_d = instr_exe;
        rd_d    = rd_addr_exe;
      end
    end
  end

  // EXE/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      rs2_q   <= '0;
      instr_q <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rs2_q   <= rs2_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
    end
  end

  assign valid_mem   = valid_q;
  assign pc_mem      = pc_q;
  assign alu_mem     = alu_q;
  assign rs2_mem     = rs2_q;
  assign instr_mem   = instr_q;
  assign rd_addr_mem = rd_q;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: forwarding/ALU retire, M-extension results
// and latency, stall_mem hold, and reset abort.
module tb_execute_md;
  import execute_md_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DW   = 10;
  localparam int unsigned NF   = 2;
  localparam int unsigned FSW  = 2;

  logic            clk, rst, valid_exe, md_en, stall_mem;
  logic [XLEN-1:0] pc_exe, rs1_exe, rs2_exe, instr_exe, imm_exe;
  logic [1:0]      a_sel, b_sel;
  logic [3:0]      alu_op;
  logic [2:0]      md_op;
  logic [4:0]      rd_addr_exe, rd_addr_mem;
  logic [FSW-1:0]  forward_a_sel, forward_b_sel;
  logic [NF*XLEN-1:0] forward_data;
  logic            stall_exe, valid_mem;
  logic [XLEN-1:0] pc_mem, alu_mem, rs2_mem, instr_mem, dmem_data;
  logic [DW-1:0]   dmem_addr;

  execute_md #(.XLEN(XLEN), .DMEM_WIDTH(DW), .FWD_SRCS(NF)) dut (
    .clk(clk), .rst(rst), .valid_exe(valid_exe), .pc_exe(pc_exe),
    .rs1_exe(rs1_exe), .rs2_exe(rs2_exe), .instr_exe(instr_exe), .imm_exe(imm_exe),
    .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op), .md_en(md_en), .md_op(md_op),
    .rd_addr_exe(rd_addr_exe), .forward_a_sel(forward_a_sel),
    .forward_b_sel(forward_b_sel), .forward_data(forward_data),
    .stall_mem(stall_mem), .stall_exe(stall_exe), .valid_mem(valid_mem),
    .pc_mem(pc_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem), .instr_mem(instr_mem),
    .rd_addr_mem(rd_addr_mem), .dmem_addr(dmem_addr), .dmem_data(dmem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input string tag, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [3:0] op, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [31:0] exp_alu, input logic [31:0] exp_rs2);
    logic [31:0] ea;
    ea = exp_alu;
    valid_exe = 1'b1; md_en = 1'b0; a_sel = asel; b_sel = bsel; alu_op = op;
    pc_exe = pc; rs1_exe = r1; rs2_exe = r2; imm_exe = imm;
    forward_a_sel = fa; forward_b_sel = fb; rd_addr_exe = 5'd3; instr_exe = 32'h0000_0033;
    #1;
    check({tag, "_stall"}, 32'(stall_exe), 32'd0);
    check({tag, "_daddr"}, 32'(dmem_addr), 32'(ea[11:2]));
    check({tag, "_ddata"}, dmem_data, exp_rs2);
    tick;
    check({tag, "_valid"}, 32'(valid_mem), 32'd1);
    check({tag, "_alu"}, alu_mem, exp_alu);
    check({tag, "_rs2"}, rs2_mem, exp_rs2);
    check({tag, "_pc"}, pc_mem, pc);
    valid_exe = 1'b0;
    forward_a_sel = '0; forward_b_sel = '0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cycles, stalls;
    bit got;
    cycles = 0; stalls = 0; got = 0;
    valid_exe = 1'b1; md_en = 1'b1; md_op = op;
    rs1_exe = 32'hDEAD_0001; forward_a_sel = 2'd1; forward_data[31:0] = a;
    rs2_exe = b; forward_b_sel = 2'd0;
    pc_exe = 32'h400; rd_addr_exe = 5'd5; instr_exe = 32'h0200_0033;
    #1;
    while (cycles < 100 && !got) begin
      if (stall_exe) stalls++;
      tick;
      cycles++;
      if (cycles == 1) forward_data[31:0] = ~a;
      if (valid_mem) got = 1;
    end
    check({tag, "_lat"}, 32'(cycles), 32'd34);
    check({tag, "_stalls"}, 32'(stalls), 32'd33);
    check({tag, "_res"}, alu_mem, exp);
    check({tag, "_rd"}, 32'(rd_addr_mem), 32'd5);
    valid_exe = 1'b0; md_en = 1'b0; forward_a_sel = '0;
  endtask

  initial begin
    int nval;
    rst = 1'b1; valid_exe = 1'b0; md_en = 1'b0; stall_mem = 1'b0;
    pc_exe = '0; rs1_exe = '0; rs2_exe = '0; instr_exe = '0; imm_exe = '0;
    a_sel = A_RS1; b_sel = B_RS2; alu_op = ALU_ADD; md_op = MD_MUL; rd_addr_exe = '0;
    forward_a_sel = '0; forward_b_sel = '0; forward_data = '0;
    tick;
    tick;
    check("rst_valid", 32'(valid_mem), 32'd0);
    check("rst_alu", alu_mem, 32'd0);
    check("rst_pc", pc_mem, 32'd0);
    check("rst_stall", 32'(stall_exe), 32'd0);
    rst = 1'b0;

    // forwarding and ALU retire
    forward_data = {32'h0000_1000, 32'd100};
    do_alu("add_fwd", A_RS1, B_RS2, ALU_ADD, 32'h100, 32'd5, 32'd7, 32'd0, 2'd1, 2'd0, 32'd107, 32'd7);
    do_alu("pc4_oor", A_PC, B_FOUR, ALU_ADD, 32'h200, 32'd1, 32'd9, 32'd0, 2'd0, 2'd3, 32'h204, 32'd9);
    do_alu("sub_fwd1", A_RS1, B_IMM, ALU_SUB, 32'h300, 32'd1, 32'd2, 32'h10, 2'd2, 2'd1, 32'h0FF0, 32'd100);
    tick;
    check("bubble_valid", 32'(valid_mem), 32'd0);
    check("bubble_hold", alu_mem, 32'h0FF0);

    // multiply/divide
    run_md("mul", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mulh", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_md("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_md("divu0", MD_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_md("remu0", MD_REMU, 32'd7, 32'd0, 32'd7);
    run_md("divs0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_md("rems0", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_md("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("removf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // stall_mem held at DONE
    valid_exe = 1'b1; md_en = 1'b1; md_op = MD_MUL; forward_a_sel = '0;
    rs1_exe = 32'd6; rs2_exe = 32'd7; pc_exe = 32'h500;
    repeat (33) tick;
    stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dstall_stall", 32'(stall_exe), 32'd1);
      tick;
      check("dstall_valid", 32'(valid_mem), 32'd0);
    end
    stall_mem = 1'b0;
    #1;
    check("dstall_release", 32'(stall_exe), 32'd0);
    tick;
    check("dstall_ret_valid", 32'(valid_mem), 32'd1);
    check("dstall_ret_res", alu_mem, 32'd42);
    check("dstall_ret_pc", pc_mem, 32'h500);
    valid_exe = 1'b0; md_en = 1'b0; stall_mem = 1'b1;
    tick;
    check("hold_valid", 32'(valid_mem), 32'd1);
    check("hold_res", alu_mem, 32'd42);
    stall_mem = 1'b0;
    tick;
    check("after_hold_valid", 32'(valid_mem), 32'd0);
    check("after_hold_res", alu_mem, 32'd42);

    // reset mid-BUSY
    valid_exe = 1'b1; md_en = 1'b1; md_op = MD_DIVU; rs1_exe = 32'd100; rs2_exe = 32'd7;
    repeat (10) tick;
    rst = 1'b1; valid_exe = 1'b0; md_en = 1'b0;
    tick;
    rst = 1'b0;
    check("rstb_valid", 32'(valid_mem), 32'd0);
    check("rstb_stall", 32'(stall_exe), 32'd0);
    check("rstb_alu", alu_mem, 32'd0);
    nval = 0;
    repeat (40) begin
      tick;
      if (valid_mem) nval++;
    end
    check("rstb_noretire", 32'(nval), 32'd0);
    do_alu("add_post", A_RS1, B_RS2, ALU_ADD, 32'h600, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0, 32'd3, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameters SHALL be:
- XLEN, 32, datapath width.
- DMEM_WIDTH, 10, word-address width of data memory.
- FWD_SRCS, 2, number of forwarding sources.
- FSW, $clog2(FWD_SRCS+1), forward-select width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- valid_exe, in, 1: ID/EXE holds a real instruction.
- pc_exe, rs1_exe, rs2_exe, instr_exe, imm_exe, in, XLEN: ID/EXE data.
- a_sel, b_sel, alu_op, in, package widths: ALU operand and operation controls.
- md_en, in, 1: the instruction is an M-extension op.
- md_op, in, 3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (encodings 0-7).
- rd_addr_exe, in, 5: destination register.
- forward_a_sel, forward_b_sel, in, FSW: 0 selects the rs value; k selects forward_data slice k-1.
- forward_data, in, FWD_SRCS*XLEN: flattened forwarding values, with slice 0 the nearest stage.
- stall_mem, in, 1: downstream cannot accept.
- stall_exe, out, 1: EXE cannot retire this cycle, so upstream holds.
- valid_mem, out, 1: EXE/MEM register holds a real instruction.
- pc_mem, alu_mem, rs2_mem, instr_mem, out, XLEN: EXE/MEM registers.
- rd_addr_mem, out, 5: EXE/MEM destination.
- dmem_addr, out, DMEM_WIDTH: equals alu_out[DMEM_WIDTH+1:2], combinational.
- dmem_data, out, XLEN: forwarded rs2, combinational.

Function
REQ-003 Operand muxing SHALL follow the existing scheme:
- forward select picks the rs value or a forward_data slice.
- an out-of-range select picks the rs value.
- A operand: RS1 / PC / ZERO; B operand: RS2 / IMM / FOUR / ZERO.
REQ-004 A non-MD instruction (valid_exe=1, md_en=0) SHALL retire in 1 cycle, capturing alu_out, pc, forwarded rs2, instr and rd, and setting valid_mem=1.
REQ-005 The MD FSM SHALL have states IDLE, BUSY and DONE.
- IDLE to BUSY when valid_exe & md_en: latch forwarded operands and md_op, set count=XLEN.
- BUSY: one radix-2 shift-add (multiply) or restoring (divide) step per cycle, count decrements; go to DONE when count reaches 0.
- DONE to IDLE when stall_mem=0: the result is written to alu_mem, with pc, instr, rd and valid_mem=1 from the held ID/EXE inputs.
REQ-006 MD latency SHALL be exactly XLEN+2 cycles from acceptance to valid_mem, with stall_mem=0 throughout.
REQ-007 Signed ops SHALL compute on magnitudes and fix the sign at the end; MULH/MULHSU/MULHU return the upper XLEN bits of the 2*XLEN product, MUL the lower.
REQ-008 Divide by zero SHALL give quotient all-ones and remainder = dividend, still taking full latency.
REQ-009 Signed overflow (-2^(XLEN-1) / -1) SHALL give quotient = dividend, remainder = 0.
REQ-010 stall_exe SHALL be:
- 1 in the IDLE acceptance cycle of an MD op,
- 1 throughout BUSY,
- 1 in DONE while stall_mem=1,
- 1 for any instruction while stall_mem=1,
- 0 otherwise.
REQ-011 When stall_mem=1, all EXE/MEM registers and valid_mem SHALL hold.
REQ-012 When EXE does not retire and stall_mem=0, valid_mem SHALL be 0 (bubble); other EXE/MEM registers hold.
REQ-013 valid_exe=0 SHALL retire a bubble: valid_mem=0 and the FSM unchanged.
REQ-014 Forwarded operands SHALL be sampled only at MD acceptance; later forward_data changes have no effect.

Reset
REQ-015 On rst=1 at a clock edge, SHALL set:
- FSM to IDLE and count to 0;
- valid_mem and all EXE/MEM outputs to 0;
- stall_exe follows from state, so it is 0 when valid_exe=0.
REQ-016 Reset during BUSY or DONE SHALL abort the operation with no result retired.

Structure
REQ-017 The XLEN default, sel encodings, md_op encodings and FSM state enum SHALL live in the shared constants package.
REQ-018 The iterative multiply/divide unit SHALL be a sub-module md_unit (start/busy/done handshake), with the existing alu instantiated unchanged.

Verification
REQ-019 ADD with rs1=5, rs2=7 and forward_a_sel=1, forward_data[0]=100 -> alu_mem=107 and valid_mem=1 one cycle later.
REQ-020 MUL 0xFFFFFFFF*0xFFFFFFFF -> MUL=1, MULHU=0xFFFFFFFE, MULH=0; each result appears after 34 cycles, with stall_exe high for 33 cycles.
REQ-021 DIV -7/2 -> q=-3 and REM -> -1; DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7.
REQ-022 DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0.
REQ-023 stall_mem held for 3 cycles at DONE -> result holds and stall_exe stays high; retires the cycle stall_mem drops.
REQ-024 rst asserted mid-BUSY -> next cycle state is IDLE and valid_mem=0; the next ADD completes normally.
